// File: rtl/bvand_ic_pkg.sv
// Shared definitions for the x & s == t Skolem solver: controller states and
// the invertibility-condition reference function.
package bvand_ic_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // x & s == t has a solution iff no bit of t is set where s is clear.
    function automatic logic ic_ref(input logic [MAX_W-1:0] s, input logic [MAX_W-1:0] t);
        return (t & ~s) == '0;
    endfunction

endpackage

// File: rtl/bvand_ic_cell.sv
// Combinational P-bit Skolem cell: per-bit witness and invertibility flag.
module bvand_ic_cell #(
    parameter int P = 1
) (
    input  logic [P-1:0] s_slice,
    input  logic [P-1:0] t_slice,
    output logic [P-1:0] x_slice,
    output logic [P-1:0] ic_slice
);

    assign x_slice  = t_slice & s_slice;
    assign ic_slice = ~(t_slice & ~s_slice);

endmodule

// File: rtl/bvand_ic_solver_seq.sv
// Sequential controller walking (s, t) P bits per cycle through the Skolem cell,
// producing witness x, ic_ok and a self-check error flag with valid/ready on both sides.
module bvand_ic_solver_seq
    import bvand_ic_pkg::*;
#(
    parameter int W = 4,
    parameter int P = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_s,
    input  logic [W-1:0] in_t,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_x,
    output logic         out_ic_ok,
    output logic         out_chk_err,
    output logic         busy
);

    localparam int NS = W / P;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NS - 1);

    if (P < 1 || P > W || (W % P) != 0) begin : g_bad_params
        $error("bvand_ic_solver_seq: P must divide W and satisfy 1 <= P <= W");
    end

    state_t        state;
    logic [W-1:0]  s_q, t_q, x_acc;
    logic          ic_acc, chk_acc;
    logic [IW-1:0] idx;

    logic [P-1:0]  s_slice, t_slice, x_slice, ic_slice;
    logic [W-1:0]  x_next;
    logic          ic_next, chk_next;

    assign s_slice = s_q[int'(idx) * P +: P];
    assign t_slice = t_q[int'(idx) * P +: P];

    bvand_ic_cell #(.P(P)) u_cell (
        .s_slice (s_slice),
        .t_slice (t_slice),
        .x_slice (x_slice),
        .ic_slice(ic_slice)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        x_next = x_acc;
        x_next[int'(idx) * P +: P] = x_slice;
    end

    assign ic_next  = ic_acc & (&ic_slice);
    assign chk_next = chk_acc | (|(((x_slice & s_slice) ^ t_slice) & ic_slice));

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            s_q         <= '0;
            t_q         <= '0;
            x_acc       <= '0;
            ic_acc      <= 1'b0;
            chk_acc     <= 1'b0;
            idx         <= '0;
            out_valid   <= 1'b0;
            out_x       <= '0;
            out_ic_ok   <= 1'b0;
            out_chk_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // flush blocks acceptance even though in_ready is high
                    if (in_valid && !flush) begin
                        s_q     <= in_s;
                        t_q     <= in_t;
                        x_acc   <= '0;
                        ic_acc  <= 1'b1;
                        chk_acc <= 1'b0;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        x_acc   <= x_next;
                        ic_acc  <= ic_next;
                        chk_acc <= chk_next;
                        if (idx == LAST) begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            out_x       <= x_next;
                            out_ic_ok   <= ic_next;
                            out_chk_err <= chk_next;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (flush || out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bvand_ic_solver_seq.sv
// Bench for bvand_ic_solver_seq: directed W=4/P=1 scenarios, random W=8/P=4 traffic
// against a word-level model, and an exhaustive sweep of a 2-bit cell.
module tb_bvand_ic_solver_seq;
    import bvand_ic_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic       a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic       a_out_ic_ok, a_out_chk_err, a_busy;
    logic [3:0] a_in_s, a_in_t, a_out_x;

    logic       b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic       b_out_ic_ok, b_out_chk_err, b_busy;
    logic [7:0] b_in_s, b_in_t, b_out_x;

    logic [1:0] c_s, c_t, c_x, c_ic;

    bvand_ic_solver_seq #(.W(4), .P(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_s(a_in_s), .in_t(a_in_t),
        .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_x(a_out_x), .out_ic_ok(a_out_ic_ok), .out_chk_err(a_out_chk_err), .busy(a_busy)
    );

    bvand_ic_solver_seq #(.W(8), .P(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_s(b_in_s), .in_t(b_in_t),
        .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_x(b_out_x), .out_ic_ok(b_out_ic_ok), .out_chk_err(b_out_chk_err), .busy(b_busy)
    );

    bvand_ic_cell #(.P(2)) u_cell (.s_slice(c_s), .t_slice(c_t), .x_slice(c_x), .ic_slice(c_ic));

    // Present a pair on A; lat counts cycles from the accept cycle (1) to the first cycle with out_valid.
    task automatic send_a(input logic [3:0] s, input logic [3:0] t, output int lat);
        @(negedge clk);
        a_in_valid = 1'b1; a_in_s = s; a_in_t = t;
        @(negedge clk);
        a_in_valid = 1'b0;
        a_in_s = 4'($urandom); a_in_t = 4'($urandom);
        lat = 1;
        while (!a_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic send_b(input logic [7:0] s, input logic [7:0] t, output int lat);
        @(negedge clk);
        b_in_valid = 1'b1; b_in_s = s; b_in_t = t;
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_s = 8'($urandom); b_in_t = 8'($urandom);
        lat = 1;
        while (!b_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a_in_valid = 0; a_in_s = 0; a_in_t = 0; a_flush = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_s = 0; b_in_t = 0; b_flush = 0; b_out_ready = 0;
        c_s = 0; c_t = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if ({a_in_ready, a_out_valid, a_out_x, a_out_ic_ok, a_out_chk_err, a_busy} !== 9'b1_0_0000_0_0_0) begin
            n_err++; $display("FAIL reset_a: got rdy=%b v=%b x=%h ic=%b chk=%b busy=%b want 1 0 0 0 0 0",
                a_in_ready, a_out_valid, a_out_x, a_out_ic_ok, a_out_chk_err, a_busy);
        end
        n_vec++; if ({b_in_ready, b_out_valid, b_out_x, b_out_ic_ok, b_out_chk_err, b_busy} !== 13'b1_0_00000000_0_0_0) begin
            n_err++; $display("FAIL reset_b: got rdy=%b v=%b x=%h ic=%b chk=%b busy=%b want 1 0 0 0 0 0",
                b_in_ready, b_out_valid, b_out_x, b_out_ic_ok, b_out_chk_err, b_busy);
        end
    endtask

    task automatic test_cell;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            c_s = v[1:0]; c_t = v[3:2];
            #1;
            n_vec++; if (c_x !== (c_s & c_t) || c_ic !== ~(c_t & ~c_s)) begin
                n_err++; $display("FAIL cell s=%b t=%b: got x=%b ic=%b want x=%b ic=%b",
                    c_s, c_t, c_x, c_ic, c_s & c_t, ~(c_t & ~c_s));
            end
        end
    endtask

    task automatic test_basic;
        logic [3:0] s_v [2];
        logic [3:0] t_v [2];
        int lat;
        s_v[0] = 4'b1011; t_v[0] = 4'b0011;
        s_v[1] = 4'b0101; t_v[1] = 4'b0110;
        for (int k = 0; k < 2; k++) begin
            send_a(s_v[k], t_v[k], lat);
            n_vec++; if (lat !== 5) begin
                n_err++; $display("FAIL basic%0d_latency: got %0d want 5", k, lat);
            end
            n_vec++; if (a_out_x !== (s_v[k] & t_v[k]) || a_out_ic_ok !== ic_ref(64'(s_v[k]), 64'(t_v[k]))
                         || a_out_chk_err !== 1'b0 || a_in_ready !== 1'b0) begin
                n_err++; $display("FAIL basic%0d_result: got x=%b ic=%b chk=%b rdy=%b want x=%b ic=%b chk=0 rdy=0",
                    k, a_out_x, a_out_ic_ok, a_out_chk_err, a_in_ready, s_v[k] & t_v[k], ic_ref(64'(s_v[k]), 64'(t_v[k])));
            end
            a_out_ready = 1'b1;
            @(negedge clk);
            a_out_ready = 1'b0;
            n_vec++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
                n_err++; $display("FAIL basic%0d_release: got v=%b rdy=%b want v=0 rdy=1", k, a_out_valid, a_in_ready);
            end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        logic [3:0] s, t;
        s = 4'b1110; t = 4'b0110;
        send_a(s, t, lat);
        for (int c = 0; c < 7; c++) begin
            n_vec++; if (a_out_valid !== 1'b1 || a_out_x !== (s & t) || a_in_ready !== 1'b0 || a_out_ic_ok !== 1'b1) begin
                n_err++; $display("FAIL backpressure_hold%0d: got v=%b x=%b rdy=%b ic=%b want v=1 x=%b rdy=0 ic=1",
                    c, a_out_valid, a_out_x, a_in_ready, a_out_ic_ok, s & t);
            end
            @(negedge clk);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        n_vec++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            n_err++; $display("FAIL backpressure_release: got v=%b rdy=%b want v=0 rdy=1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_flush;
        int lat;
        int seen;
        @(negedge clk);
        a_in_valid = 1'b1; a_in_s = 4'hF; a_in_t = 4'hA;
        @(negedge clk);                       // accepted; first RUN cycle
        a_in_valid = 1'b0;
        @(negedge clk);                       // second RUN cycle
        a_flush = 1'b1;
        @(negedge clk);
        a_flush = 1'b0;
        n_vec++; if (a_busy !== 1'b0 || a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_run: got busy=%b rdy=%b v=%b want 0 1 0", a_busy, a_in_ready, a_out_valid);
        end
        seen = 0;
        repeat (8) begin @(negedge clk); if (a_out_valid) seen++; end
        n_vec++; if (seen !== 0) begin
            n_err++; $display("FAIL flush_no_result: got %0d valid cycles want 0", seen);
        end
        send_a(4'h0, 4'h0, lat);
        n_vec++; if (lat !== 5 || a_out_x !== 4'h0 || a_out_ic_ok !== 1'b1) begin
            n_err++; $display("FAIL flush_next: got lat=%0d x=%h ic=%b want 5 0 1", lat, a_out_x, a_out_ic_ok);
        end
        // flush together with out_ready in DONE drops the result
        a_flush = 1'b1; a_out_ready = 1'b1;
        @(negedge clk);
        a_flush = 1'b0; a_out_ready = 1'b0;
        n_vec++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            n_err++; $display("FAIL flush_done: got v=%b rdy=%b want 0 1", a_out_valid, a_in_ready);
        end
        // flush in IDLE wins over in_valid
        a_flush = 1'b1; a_in_valid = 1'b1; a_in_s = 4'h3; a_in_t = 4'h1;
        @(negedge clk);
        a_flush = 1'b0; a_in_valid = 1'b0;
        n_vec++; if (a_busy !== 1'b0) begin
            n_err++; $display("FAIL flush_idle: got busy=%b want 0", a_busy);
        end
    endtask

    task automatic test_reset_mid_run;
        int lat;
        int seen;
        send_a(4'hF, 4'h5, lat);              // leave nonzero output registers
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_s = 4'hC; a_in_t = 4'h4;
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if ({a_in_ready, a_out_valid, a_out_x, a_out_ic_ok, a_out_chk_err, a_busy} !== 9'b1_0_0000_0_0_0) begin
            n_err++; $display("FAIL reset_async: got rdy=%b v=%b x=%h ic=%b chk=%b busy=%b want 1 0 0 0 0 0",
                a_in_ready, a_out_valid, a_out_x, a_out_ic_ok, a_out_chk_err, a_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin @(negedge clk); if (a_out_valid || !a_in_ready) seen++; end
        n_vec++; if (seen !== 0) begin
            n_err++; $display("FAIL reset_no_stale: got %0d bad cycles want 0", seen);
        end
    endtask

    task automatic test_random_b;
        int lat;
        logic [7:0] s, t;
        logic [7:0] x_exp;
        logic       ic_exp;
        for (int n = 0; n < 1000; n++) begin
            s = 8'($urandom); t = 8'($urandom);
            if (n % 4 == 0) t = t & s;        // bias towards solvable pairs
            x_exp  = s & t;
            ic_exp = ic_ref(64'(s), 64'(t));
            send_b(s, t, lat);
            n_vec++; if (lat !== 3) begin
                n_err++; $display("FAIL rand%0d_latency: got %0d want 3", n, lat);
            end
            n_vec++; if (b_out_x !== x_exp || b_out_ic_ok !== ic_exp || b_out_chk_err !== 1'b0) begin
                n_err++; $display("FAIL rand%0d s=%h t=%h: got x=%h ic=%b chk=%b want x=%h ic=%b chk=0",
                    n, s, t, b_out_x, b_out_ic_ok, b_out_chk_err, x_exp, ic_exp);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            n_vec++; if (b_out_valid !== 1'b1 || b_out_x !== x_exp) begin
                n_err++; $display("FAIL rand%0d_hold: got v=%b x=%h want v=1 x=%h", n, b_out_valid, b_out_x, x_exp);
            end
            b_out_ready = 1'b1;
            @(negedge clk);
            b_out_ready = 1'b0;
            n_vec++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
                n_err++; $display("FAIL rand%0d_release: got v=%b rdy=%b want 0 1", n, b_out_valid, b_in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cell();
        test_basic();
        test_backpressure();
        test_flush();
        test_reset_mid_run();
        test_random_b();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bvand_ic_solver_seq.md
Name: bvand_ic_solver_seq

Overview:
- Sequential controller that drives a bit-sliced Skolem cell for the bit-vector equation x & s == t.
- Accepts one (s, t) operand pair per transaction and walks the W-bit vectors P bits per cycle.
- Produces a witness x and the invertibility-condition flag ic_ok. ic_ok is 1 iff (t & ~s) == 0.
- Sits between the operand source (solver front end) and the result consumer (model checker / verifier), with valid/ready on both sides.

Parameters:
- W, 4: operand width in bits; W >= 1.
- P, 1: bits processed per cycle; 1 <= P <= W; W % P == 0 (enforced by elaboration-time check).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_s  input  W  operand s.
- in_t  input  W  target t.
- flush  input  1  synchronous abort of the current transaction.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_x  output  W  witness x.
- out_ic_ok  output  1  invertibility condition holds.
- out_chk_err  output  1  self-check mismatch: (out_x & s) != t while out_ic_ok = 1. This is 0 in a correct design.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all internal registers zeroed.
  - Reset values: in_ready=1, out_valid=0, out_x=0, out_ic_ok=0, out_chk_err=0, busy=0.
  - Reset asserted mid-transaction discards all work. No result is emitted afterwards.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid & in_ready: latch s and t into shift registers, clear x_acc, set ic_acc=1, set idx=0, go to RUN.
- RUN (in_ready=0):
  - Each cycle, feed slice bits [idx*P +: P] of s and t to the bit cell.
  - Shift the cell's x bits into x_acc at the same positions.
  - Update ic_acc &= AND of the cell ic bits.
  - Update chk_acc |= OR over the slice of ((x_i & s_i) != t_i) & cell_ic_i.
  - idx increments by 1 each cycle. When idx == W/P-1, go to DONE on the next edge.
  - RUN lasts exactly W/P cycles.
- DONE:
  - out_valid=1; out_x, out_ic_ok, out_chk_err hold stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready, go to IDLE; out_valid drops on the next edge.
  - Output registers keep their last values in IDLE. They are only meaningful while out_valid=1.
- Latency: accept edge to out_valid high is W/P+1 cycles. Throughput is one transaction per W/P+2 cycles at best.
- in_ready is registered-state-derived only: in_ready = (state == IDLE). There is no combinational path from out_ready to in_ready.
- flush:
  - In RUN or DONE: go to IDLE on the next edge. out_valid drops and no handshake completes.
  - In IDLE: ignored. If flush and in_valid are both high in IDLE, the input is NOT accepted (flush wins).
- Simultaneous flush and out_ready in DONE: flush wins and the result is considered dropped.
- Per-bit Skolem rule (bit cell, combinational):
  - x_i = t_i & s_i.
  - ic_i = ~(t_i & ~s_i).
- Width rules: idx width = clog2(W/P), with a minimum of 1 bit. No arithmetic beyond the idx increment, and idx never wraps inside RUN.
- in_s/in_t are sampled only on the accept edge. Later changes on these inputs have no effect.

Decomposition:
- Shared package bvand_ic_pkg:
  - FSM state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Function ic_ref(s,t) returning (t & ~s) == 0, reused by the bench scoreboard.
- Sub-module bvand_ic_cell: purely combinational, P-bit wide.
  - Inputs: s_slice, t_slice.
  - Outputs: x_slice, ic_slice.
  - The controller instantiates it once. Verification can exhaustively check it standalone (all 2^(2P) inputs).

Test Plan:
- W=4, P=1: in_s=4'b1011, in_t=4'b0011 accepted -> out_valid after 5 cycles, out_x=4'b0011, out_ic_ok=1, out_chk_err=0.
- W=4, P=1: in_s=4'b0101, in_t=4'b0110 -> out_x=4'b0100, out_ic_ok=0 (bit 1 has t=1 with s=0).
- Back-pressure: out_ready held 0 for 7 cycles in DONE -> out_valid and out_x stable throughout, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
- flush asserted on the 2nd RUN cycle of s=4'hF, t=4'hA -> IDLE next edge, no out_valid pulse. The next pair s=4'h0, t=4'h0 gives out_x=0, out_ic_ok=1.
- rst_n pulsed low mid-RUN -> all outputs take reset values immediately (async). After release, in_ready=1 and no stale result appears.
- W=8, P=4: random 1000 pairs against ic_ref -> each result after 3 cycles. out_ic_ok matches ic_ref and out_x equals s&t on every result; out_chk_err is never 1.
